// File: rtl/mem_port_arbiter.sv
// Two-master memory port arbiter: the instruction fetch port (read-only) and
// the load/store port (read/write) share one single-ported memory. One
// transaction is in flight at a time. The memory request lines come only from
// the FSM state and from the latched copies of the request, so they stay
// stable until the memory signals completion.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    // instruction fetch port
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_ready,
    output logic                i_valid,
    output logic [DATA_W-1:0]   i_rdata,
    // load/store port
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W/8-1:0] d_wmask,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_ready,
    output logic                d_valid,
    output logic [DATA_W-1:0]   d_rdata,
    // memory side
    output logic                m_rreq,
    output logic [ADDR_W-1:0]   m_raddr,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_data_valid,
    output logic                m_wreq,
    output logic [ADDR_W-1:0]   m_waddr,
    output logic [DATA_W/8-1:0] m_wmask,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_write_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        I_RD = 2'd1,
        D_RD = 2'd2,
        D_WR = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_last_d;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W/8-1:0] r_wmask;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_i_valid;
    logic                r_d_valid;
    logic [DATA_W-1:0]   r_i_rdata;
    logic [DATA_W-1:0]   r_d_rdata;

    logic w_idle;
    logic w_grant_i;
    logic w_grant_d;
    logic w_rd_done_i;
    logic w_rd_done_d;
    logic w_wr_done;

    // On a tie the master that did not win last time is granted. Grants are
    // suppressed while reset is held so no master sees a phantom accept.
    assign w_idle      = (r_state == IDLE) && !reset;
    assign w_grant_i   = w_idle && i_req && (!d_req || r_last_d);
    assign w_grant_d   = w_idle && d_req && (!i_req || !r_last_d);
    assign w_rd_done_i = (r_state == I_RD) && m_data_valid;
    assign w_rd_done_d = (r_state == D_RD) && m_data_valid;
    assign w_wr_done   = (r_state == D_WR) && m_write_done;

    assign i_ready = w_grant_i;
    assign d_ready = w_grant_d;
    assign i_valid = r_i_valid;
    assign d_valid = r_d_valid;
    assign i_rdata = r_i_rdata;
    assign d_rdata = r_d_rdata;

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state logic: completions of the wrong kind are ignored
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_i)      w_state_next = I_RD;
                else if (w_grant_d) w_state_next = d_we ? D_WR : D_RD;
            end
            I_RD: if (m_data_valid) w_state_next = IDLE;
            D_RD: if (m_data_valid) w_state_next = IDLE;
            D_WR: if (m_write_done) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Memory request strobes decoded from state only
    always_comb begin
        m_rreq = 1'b0;
        m_wreq = 1'b0;
        case (r_state)
            I_RD:    m_rreq = 1'b1;
            D_RD:    m_rreq = 1'b1;
            D_WR:    m_wreq = 1'b1;
            default: ;
        endcase
    end

    assign m_raddr = r_addr;
    assign m_waddr = r_addr;
    assign m_wmask = r_wmask;
    assign m_wdata = r_wdata;

    // Latch the granted master's request so later input changes have no effect
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_d <= 1'b1;
            r_addr   <= '0;
            r_wmask  <= '0;
            r_wdata  <= '0;
        end else if (w_grant_i) begin
            r_last_d <= 1'b0;
            r_addr   <= i_addr;
        end else if (w_grant_d) begin
            r_last_d <= 1'b1;
            r_addr   <= d_addr;
            r_wmask  <= d_wmask;
            r_wdata  <= d_wdata;
        end
    end

    // Registered responses: one-cycle valid pulses, rdata held until next completion
    always_ff @(posedge clk) begin
        if (reset) begin
            r_i_valid <= 1'b0;
            r_d_valid <= 1'b0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            r_i_valid <= w_rd_done_i;
            r_d_valid <= w_rd_done_d || w_wr_done;
            if (w_rd_done_i) r_i_rdata <= m_rdata;
            if (w_rd_done_d) r_d_rdata <= m_rdata;
            else if (w_wr_done) r_d_rdata <= '0;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of single transactions against
// a variable-latency memory model, plus hand-written round-robin, reset-abort
// and reset-state sequences.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ready;
    logic        i_valid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [3:0]  d_wmask;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        m_rreq;
    logic [31:0] m_raddr;
    logic [31:0] m_rdata;
    logic        m_data_valid;
    logic        m_wreq;
    logic [31:0] m_waddr;
    logic [3:0]  m_wmask;
    logic [31:0] m_wdata;
    logic        m_write_done;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready),
        .i_valid(i_valid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wmask(d_wmask),
        .d_wdata(d_wdata), .d_ready(d_ready), .d_valid(d_valid), .d_rdata(d_rdata),
        .m_rreq(m_rreq), .m_raddr(m_raddr), .m_rdata(m_rdata),
        .m_data_valid(m_data_valid),
        .m_wreq(m_wreq), .m_waddr(m_waddr), .m_wmask(m_wmask), .m_wdata(m_wdata),
        .m_write_done(m_write_done)
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    // Memory model: samples requests 1 time unit after each edge; a request seen
    // in cycle N completes (pulse driven) in cycle N+1+cur_delay. With cur_spur
    // set, it also drives the opposite completion pulse once, early.
    logic [31:0] mem [0:63];
    int          cur_delay = 0;
    bit          cur_spur  = 1'b0;

    initial begin
        int          cnt;
        bit          busy;
        bit          is_wr;
        logic [5:0]  a;
        logic [31:0] wd;
        logic [3:0]  wm;
        logic [31:0] old;
        busy = 1'b0; cnt = 0; is_wr = 1'b0; a = '0; wd = '0; wm = '0;
        m_data_valid = 1'b0;
        m_write_done = 1'b0;
        m_rdata      = '0;
        forever begin
            @(posedge clk); #1;
            m_data_valid = 1'b0;
            m_write_done = 1'b0;
            if (busy) begin
                if (cnt == 0) begin
                    if (is_wr) begin
                        old = mem[a];
                        for (int b = 0; b < 4; b++)
                            if (wm[b]) old[b*8 +: 8] = wd[b*8 +: 8];
                        mem[a] = old;
                        m_write_done = 1'b1;
                    end else begin
                        m_rdata      = mem[a];
                        m_data_valid = 1'b1;
                    end
                    busy = 1'b0;
                end else begin
                    if (cur_spur && cnt == cur_delay) begin
                        if (is_wr) begin
                            m_rdata      = 32'hBAD0BAD0;
                            m_data_valid = 1'b1;
                        end else begin
                            m_write_done = 1'b1;
                        end
                    end
                    cnt--;
                end
            end else if (m_rreq || m_wreq) begin
                busy  = 1'b1;
                cnt   = cur_delay;
                is_wr = m_wreq;
                a     = m_wreq ? m_waddr[5:0] : m_raddr[5:0];
                wd    = m_wdata;
                wm    = m_wmask;
            end
        end
    end

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [3:0]  wmask;
        logic [31:0] wdata;
        int          delay;
        bit          spur;
        logic [31:0] exp_rdata;
    } txn_t;

    txn_t tbl [10];

    // Issue one transaction, scramble master inputs after accept, and check
    // grant, request stability, latency (3 + delay) and the response.
    task automatic run_txn(input int idx, input txn_t t);
        int          lat;
        bit          got;
        bit          other;
        bit          stable;
        bit          wr;
        logic [31:0] first_addr;
        wr        = t.is_d && t.we;
        cur_delay = t.delay;
        cur_spur  = t.spur;
        @(posedge clk); #1;
        if (t.is_d) begin
            d_req = 1'b1; d_we = t.we; d_addr = t.addr;
            d_wmask = t.wmask; d_wdata = t.wdata;
        end else begin
            i_req = 1'b1; i_addr = t.addr;
        end
        #1;
        chk($sformatf("t%0d_ready", idx), 32'(t.is_d ? d_ready : i_ready), 32'd1);
        chk($sformatf("t%0d_other_ready", idx), 32'(t.is_d ? i_ready : d_ready), 32'd0);
        @(posedge clk); #1;
        i_req = 1'b0; d_req = 1'b0;
        i_addr = ~t.addr; d_addr = ~t.addr; d_wdata = ~t.wdata;
        d_wmask = ~t.wmask; d_we = ~t.we;
        lat = 1;
        first_addr = wr ? m_waddr : m_raddr;
        chk($sformatf("t%0d_first_addr", idx), first_addr, t.addr);
        chk($sformatf("t%0d_req_line", idx), 32'(wr ? m_wreq : m_rreq), 32'd1);
        stable = 1'b1; other = 1'b0; got = 1'b0;
        while (!got && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (t.is_d ? d_valid : i_valid) begin
                got = 1'b1;
            end else if (wr) begin
                stable &= bit'(m_wreq && m_waddr == t.addr && m_wdata == t.wdata
                               && m_wmask == t.wmask && !m_rreq);
            end else begin
                stable &= bit'(m_rreq && m_raddr == t.addr && !m_wreq);
            end
            if (t.is_d ? i_valid : d_valid) other = 1'b1;
        end
        chk($sformatf("t%0d_latency", idx), 32'(lat), 32'(3 + t.delay));
        chk($sformatf("t%0d_rdata", idx), t.is_d ? d_rdata : i_rdata, t.exp_rdata);
        chk($sformatf("t%0d_stable", idx), 32'(stable), 32'd1);
        chk($sformatf("t%0d_other_valid", idx), 32'(other), 32'd0);
        chk($sformatf("t%0d_idle_at_valid", idx), 32'(m_rreq | m_wreq), 32'd0);
        $display("txn %0d: %s %s addr=%0d delay=%0d lat=%0d rdata=%h",
                 idx, t.is_d ? "D" : "I", wr ? "WR" : "RD", t.addr, t.delay, lat,
                 t.is_d ? d_rdata : i_rdata);
        @(posedge clk); #1;
        chk($sformatf("t%0d_valid_pulse", idx), 32'(t.is_d ? d_valid : i_valid), 32'd0);
        chk($sformatf("t%0d_rdata_hold", idx), t.is_d ? d_rdata : i_rdata, t.exp_rdata);
    endtask

    initial begin
        string       grants;
        string       exp_g;
        bit          both;
        bit          seen;

        for (int i = 0; i < 64; i++) mem[i] = i * 32'h01010101;
        mem[8] = 32'h11223344;

        //           is_d we addr  wmask    wdata         dly spur exp
        tbl[0] = '{1'b0, 1'b0, 32'd4, 4'b0000, 32'h0,        0, 1'b0, 32'h04040404};
        tbl[1] = '{1'b1, 1'b1, 32'd8, 4'b0011, 32'hDEADBEEF, 0, 1'b0, 32'h0};
        tbl[2] = '{1'b1, 1'b0, 32'd8, 4'b0000, 32'h0,        0, 1'b0, 32'h1122BEEF};
        tbl[3] = '{1'b0, 1'b0, 32'd8, 4'b0000, 32'h0,        3, 1'b1, 32'h1122BEEF};
        tbl[4] = '{1'b1, 1'b1, 32'd5, 4'b0000, 32'hFFFFFFFF, 2, 1'b0, 32'h0};
        tbl[5] = '{1'b1, 1'b0, 32'd5, 4'b0000, 32'h0,        1, 1'b0, 32'h05050505};
        tbl[6] = '{1'b1, 1'b1, 32'd6, 4'b1100, 32'hAABBCCDD, 5, 1'b1, 32'h0};
        tbl[7] = '{1'b0, 1'b0, 32'd6, 4'b0000, 32'h0,       31, 1'b0, 32'hAABB0606};
        tbl[8] = '{1'b1, 1'b1, 32'd7, 4'b1111, 32'h12345678, 7, 1'b0, 32'h0};
        tbl[9] = '{1'b1, 1'b0, 32'd7, 4'b0000, 32'h0,        0, 1'b0, 32'h12345678};

        reset = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wmask = '0; d_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_i_valid", 32'(i_valid), 32'd0);
        chk("rst_d_valid", 32'(d_valid), 32'd0);
        chk("rst_ready", 32'(i_ready | d_ready), 32'd0);
        chk("rst_m_rreq", 32'(m_rreq), 32'd0);
        chk("rst_m_wreq", 32'(m_wreq), 32'd0);
        chk("rst_i_rdata", i_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_m_raddr", m_raddr, 32'd0);
        chk("rst_m_wdata", m_wdata, 32'd0);
        chk("rst_m_wmask", 32'(m_wmask), 32'd0);
        reset = 1'b0;

        // Both masters requesting continuously: grants alternate starting with fetch
        cur_delay = 0; cur_spur = 1'b0;
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 32'd1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'd2;
        grants = ""; both = 1'b0;
        for (int c = 0; c < 60 && grants.len() < 4; c++) begin
            #1;
            if (i_ready && d_ready) both = 1'b1;
            if (i_ready) grants = {grants, "I"};
            else if (d_ready) grants = {grants, "D"};
            @(posedge clk); #1;
        end
        i_req = 1'b0; d_req = 1'b0;
        exp_g = "IDID";
        chk("rr_count", 32'(grants.len()), 32'd4);
        for (int g = 0; g < 4; g++)
            chk($sformatf("rr_grant%0d", g), 32'(grants.len() > g ? grants[g] : 8'h0),
                32'(exp_g[g]));
        chk("rr_both_ready", 32'(both), 32'd0);
        $display("round robin grants: %s", grants);
        repeat (6) @(posedge clk);

        for (int i = 0; i < 10; i++) run_txn(i, tbl[i]);

        // Reset in the middle of a slow LSU read aborts it without a valid pulse
        cur_delay = 20; cur_spur = 1'b0;
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'd3;
        @(posedge clk); #1;
        d_req = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        chk("abort_pre_rreq", 32'(m_rreq), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_rreq_drop", 32'(m_rreq), 32'd0);
        chk("abort_d_rdata_clr", d_rdata, 32'd0);
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (d_valid || i_valid) seen = 1'b1;
        end
        chk("abort_no_valid", 32'(seen), 32'd0);
        $display("reset abort: valid seen=%0d", seen);
        run_txn(10, '{1'b0, 1'b0, 32'd4, 4'b0000, 32'h0, 1, 1'b0, 32'h04040404});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-master arbiter that shares the single-ported synchronous read/write memory model between the instruction-fetch port (read-only) and the load/store port (read/write). It accepts one transaction at a time and holds the memory request lines stable until the memory's variable-latency completion pulse. It then returns the response, registered, to the originating master. Sits between the core's fetch/LSU and the memory model in the simulation top.

## Interface
- ADDR_W, 32, address width, passed through unchanged (word index into memory)
- DATA_W, 32, data width; wmask width is DATA_W/8

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- i_req  in  1  fetch read request
- i_addr  in  ADDR_W  fetch address
- i_ready  out  1  fetch request accepted this cycle (combinational)
- i_valid  out  1  fetch data valid, one-cycle pulse
- i_rdata  out  DATA_W  fetch data
- d_req  in  1  LSU request
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  LSU address
- d_wmask  in  DATA_W/8  byte write enables
- d_wdata  in  DATA_W  write data
- d_ready  out  1  LSU request accepted this cycle (combinational)
- d_valid  out  1  LSU read data valid or write complete, one-cycle pulse
- d_rdata  out  DATA_W  LSU read data (0 for writes)
- m_rreq, m_raddr  out  1, ADDR_W  memory read request/address
- m_rdata, m_data_valid  in  DATA_W, 1  memory read data/valid
- m_wreq, m_waddr, m_wmask, m_wdata  out  1, ADDR_W, DATA_W/8, DATA_W  memory write request
- m_write_done  in  1  memory write completion

## Operation
- FSM states: IDLE, I_RD, D_RD, D_WR.
- IDLE: if exactly one of i_req/d_req is high, grant it. If both are high, grant the master that was not granted last (round-robin via `last_d` flag). Grant asserts that master's ready for the cycle. Address/wmask/wdata/we are latched into internal registers at that edge. Next state is I_RD, D_RD (d_we=0) or D_WR (d_we=1).
- I_RD/D_RD: m_rreq=1, m_raddr=latched addr. On m_data_valid: capture m_rdata into the owner's rdata register, pulse the owner's valid next cycle, and go to IDLE.
- D_WR: m_wreq=1, m_waddr/m_wmask/m_wdata=latched values. On m_write_done: pulse d_valid next cycle with d_rdata=0, and go to IDLE.
- Memory request outputs are decoded from state only. They never depend on current master inputs, so they stay stable for the whole transaction.
- i_ready/d_ready are only ever high in IDLE, and never both in one cycle.
- m_data_valid in D_WR or IDLE, and m_write_done in read states or IDLE, are ignored.
- d_wmask=0 write is still issued and completes normally.
- Masters may drop or change req/addr after ready without effect. The latched copy is used.

## Timing
- Reset: state IDLE, last_d=1 (fetch wins the first tie), all ready/valid/m_rreq/m_wreq=0, rdata registers 0, address/data registers 0.
- Accept at cycle T. m_rreq/m_wreq high from T+1. Completion seen at cycle C (C≥T+2 with zero memory delay). Owner valid/rdata at C+1, state IDLE at C+1.
- Minimum accept-to-valid latency: 3 cycles. Back-to-back throughput: one transaction per 3 cycles plus memory delay.
- A new grant may occur in the same cycle as the previous valid pulse (state already IDLE at C+1).
- rdata registers hold their value after valid until the next completion for that master.
- Reset mid-transaction: abort immediately, no valid pulse, m_rreq/m_wreq drop next cycle.

## Test plan
- Single fetch, i_addr=4, memory delay 0 -> i_ready at T, m_rreq high T+1..T+2, i_valid with i_rdata=mem[4] at T+3, d_valid never high.
- LSU write 0xDEADBEEF, wmask=4'b0011 to addr 8 (old 0x11223344), then read 8 -> d_valid after write with d_rdata=0; read returns 0x1122BEEF.
- i_req and d_req held high continuously -> grants alternate I,D,I,D starting with I after reset; no cycle has both ready.
- Random memory delays 0–31: m_raddr/m_waddr/m_wdata unchanged from first request cycle to completion, even when masters change inputs after ready.
- Assert reset during D_RD with delay 20 -> no d_valid, m_rreq=0 next cycle; a subsequent fetch completes correctly.
- Spurious m_write_done during I_RD -> ignored; i_valid only on m_data_valid.
